// File: rtl/shift_pkg.sv
// Shared types for the iterative shift unit: operation modes and FSM states.
package shift_pkg;

    typedef enum logic [1:0] {
        SHIFT_SLL  = 2'b00,
        SHIFT_SRL  = 2'b01,
        SHIFT_SRA  = 2'b10,
        SHIFT_ROTR = 2'b11
    } shift_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

endpackage

// File: rtl/shift_step.sv
// Combinational single-step shifter: moves data by k (0..STEP) places and flags any 1 bit lost.
// Rotate right is built only when SHIFT_ROTATE_EN is defined; otherwise mode 11 behaves as SLL.
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] data,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       mode,
    input  logic             fill,
    output logic [WIDTH-1:0] shifted,
    output logic             lost
);

    localparam logic [WIDTH-1:0] ONES = {WIDTH{1'b1}};

    logic sra_fill;

    assign sra_fill = fill & (shift_mode_e'(mode) == SHIFT_SRA);

    always_comb begin
        shifted = data << k;
        lost    = |(data & ~(ONES >> k));
        case (shift_mode_e'(mode))
            SHIFT_SRL, SHIFT_SRA: begin
                // Right shifts: vacated top bits take the captured sign (SRA) or zero.
                shifted = (data >> k) | (sra_fill ? ~(ONES >> k) : '0);
                lost    = |(data & ~(ONES << k));
            end
`ifdef SHIFT_ROTATE_EN
            SHIFT_ROTR: begin
                shifted = (data >> k) | (data << (WIDTH - int'(k)));
                lost    = 1'b0;
            end
`else
            SHIFT_ROTR: ;
`endif
            default: ;
        endcase
    end

endmodule

// File: rtl/shift_unit.sv
// Iterative SLL/SRL/SRA(/ROTR) shifter with valid/ready handshakes, up to STEP places per cycle.
// Define SHIFT_ROTATE_EN to build rotate right for mode 11; otherwise mode 11 executes as SLL.
module shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int STEP  = 4,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [SHW-1:0]   in_shamt,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_lost
);

    localparam int             KW     = $clog2(STEP + 1);
    localparam logic [SHW:0]   STEP_V = (SHW + 1)'(STEP);

    shift_state_e     state;
    shift_mode_e      mode_q;
    logic [WIDTH-1:0] data_q;
    logic [SHW-1:0]   rem_q;
    logic             fill_q;
    logic             lost_q;

    logic [KW-1:0]    k;
    logic [SHW-1:0]   rem_next;
    logic [WIDTH-1:0] step_data;
    logic             step_lost;

    // The final partial step takes whatever amount remains.
    assign k        = ({1'b0, rem_q} < STEP_V) ? KW'(rem_q) : KW'(STEP);
    assign rem_next = rem_q - SHW'(k);

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP),
        .KW    (KW)
    ) u_step (
        .data    (data_q),
        .k       (k),
        .mode    (mode_q),
        .fill    (fill_q),
        .shifted (step_data),
        .lost    (step_lost)
    );

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            mode_q    <= SHIFT_SLL;
            data_q    <= '0;
            rem_q     <= '0;
            fill_q    <= 1'b0;
            lost_q    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        data_q   <= in_data;
                        mode_q   <= shift_mode_e'(in_mode);
                        rem_q    <= in_shamt;
                        fill_q   <= in_data[WIDTH-1];
                        lost_q   <= 1'b0;
                        in_ready <= 1'b0;
                        if (in_shamt != '0) begin
                            state <= ST_SHIFT;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_SHIFT: begin
                    data_q <= step_data;
                    lost_q <= lost_q | step_lost;
                    rem_q  <= rem_next;
                    if (rem_next == '0) begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data = data_q;
    assign out_lost = lost_q;

endmodule

// File: tb/tb_shift_unit.sv
// Directed bench for shift_unit (WIDTH=32, STEP=4) with hand-computed expected results.
module tb_shift_unit;

    logic        Clk;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [4:0]  in_shamt;
    logic [1:0]  in_mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_lost;

    int checks = 0;
    int errors = 0;
    int edges;
    logic [31:0] held;

    shift_unit #(.WIDTH(32), .STEP(4)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_shamt  (in_shamt),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_lost  (out_lost)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Present one operand and complete the accept edge.
    task automatic send(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m, input string tag);
        in_data  = d;
        in_shamt = sh;
        in_mode  = m;
        in_valid = 1'b1;
        chk({tag, " in_ready"}, {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        edges    = 1;
    endtask

    // Count edges from the accept edge (inclusive) until out_valid.
    task automatic wait_valid(input int exp_edges, input string tag);
        while (out_valid !== 1'b1 && edges < 64) begin
            tick();
            edges++;
        end
        chk({tag, " latency"}, 32'(edges), 32'(exp_edges));
    endtask

    task automatic take(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, " out_valid after take"}, {31'b0, out_valid}, 32'd0);
        chk({tag, " in_ready after take"}, {31'b0, in_ready}, 32'd1);
    endtask

    task automatic run_op(input logic [31:0] d, input logic [4:0] sh, input logic [1:0] m,
                          input logic [31:0] exp_d, input logic exp_lost, input int exp_edges,
                          input string tag);
        send(d, sh, m, tag);
        wait_valid(exp_edges, tag);
        chk({tag, " data"}, out_data, exp_d);
        chk({tag, " lost"}, {31'b0, out_lost}, {31'b0, exp_lost});
        take(tag);
    endtask

    initial begin
        Reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_shamt  = '0;
        in_mode   = 2'b00;
        out_ready = 1'b0;
        #2;
        chk("reset in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset out_data", out_data, 32'h0);
        chk("reset out_lost", {31'b0, out_lost}, 32'd0);
        tick();
        tick();
        Reset = 1'b0;
        tick();

        run_op(32'h0000_0001, 5'd2,  2'b00, 32'h0000_0004, 1'b0, 2, "sll2");
        run_op(32'h8000_0000, 5'd31, 2'b10, 32'hFFFF_FFFF, 1'b0, 9, "sra31");
        run_op(32'hC000_0000, 5'd1,  2'b00, 32'h8000_0000, 1'b1, 2, "sll_loss");
        run_op(32'h0000_0003, 5'd1,  2'b01, 32'h0000_0001, 1'b1, 2, "srl_loss");
        run_op(32'h8000_00F0, 5'd9,  2'b01, 32'h0040_0000, 1'b1, 4, "srl9");
        run_op(32'h4000_0000, 5'd5,  2'b10, 32'h0200_0000, 1'b0, 3, "sra_pos");
        run_op(32'h0000_00F1, 5'd0,  2'b11, 32'h0000_00F1, 1'b0, 1, "mode3_zero");
`ifdef SHIFT_ROTATE_EN
        run_op(32'h0000_00F1, 5'd4,  2'b11, 32'h1000_000F, 1'b0, 2, "rotr4");
        run_op(32'h0000_0001, 5'd31, 2'b11, 32'h0000_0002, 1'b0, 9, "rotr31");
`else
        run_op(32'h0000_00F1, 5'd4,  2'b11, 32'h0000_0F10, 1'b0, 2, "mode3_sll4");
        run_op(32'h8000_0001, 5'd31, 2'b11, 32'h8000_0000, 1'b1, 9, "mode3_sll31");
`endif

        // Backpressure: hold DONE for 5 cycles with a stray in_valid pulse.
        send(32'h0000_0001, 5'd2, 2'b00, "bp");
        wait_valid(2, "bp");
        held = out_data;
        chk("bp data", held, 32'h0000_0004);
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                in_data  = 32'hDEAD_BEEF;
                in_shamt = 5'd3;
                in_valid = 1'b1;
            end
            if (i == 3) in_valid = 1'b0;
            tick();
            chk("bp out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp data stable", out_data, 32'h0000_0004);
            chk("bp in_ready", {31'b0, in_ready}, 32'd0);
        end
        take("bp");
        run_op(32'h0000_0010, 5'd1, 2'b01, 32'h0000_0008, 1'b0, 2, "after_bp");

        // Reset during the third SHIFT cycle of a 20-place SRL.
        send(32'hFFFF_FFFF, 5'd20, 2'b01, "rst_mid");
        tick();
        tick();
        chk("rst_mid still busy", {31'b0, out_valid}, 32'd0);
        Reset = 1'b1;
        #1;
        chk("rst_mid out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_mid out_data", out_data, 32'h0);
        tick();
        Reset = 1'b0;
        tick();
        chk("rst_mid no result", {31'b0, out_valid}, 32'd0);
        run_op(32'hF000_0000, 5'd4, 2'b01, 32'h0F00_0000, 1'b0, 2, "post_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/shift_unit.md
# shift_unit

Parametrised, iterative shift unit that generalises the fixed shift-left-by-2 address path into a general shifter for the MIPS datapath. It supports logical left, logical right, arithmetic right and, optionally, rotate right. The operand width and the bits shifted per cycle are parameters. Operands enter and results leave through valid/ready handshakes. It sits beside the ALU and serves SLL/SRL/SRA/SLLV/SRLV/SRAV, trading latency for area when STEP is small.

## Interface
- WIDTH, 32: operand and result width; power of two, ≥ 2.
- STEP, 4: maximum bit positions shifted per cycle; 1 ≤ STEP ≤ WIDTH.
- SHW, $clog2(WIDTH): shift-amount width (derived; not overridden).

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand presented.
- in_ready  output  1  unit can accept an operand; high only in IDLE.
- in_data  input  WIDTH  operand.
- in_shamt  input  SHW  shift amount.
- in_mode  input  2  00 SLL, 01 SRL, 10 SRA, 11 ROTR.
- out_valid  output  1  result held.
- out_ready  input  1  consumer accepts the result.
- out_data  output  WIDTH  shifted result.
- out_lost  output  1  sticky flag: a 1 bit was shifted out (SLL/SRL/SRA); always 0 for ROTR.

## Operation
- FSM states and transitions:
  - IDLE: in_ready=1. A handshake (in_valid & in_ready) loads data, mode, remaining=in_shamt and fill, and clears lost. The next state is SHIFT if in_shamt≠0, otherwise DONE.
  - SHIFT: each cycle shifts by k=min(STEP, remaining) and sets remaining -= k. Lost is ORed with every 1 bit shifted out. When remaining reaches 0, the next state is DONE.
  - DONE: out_valid=1 and out_data/out_lost are stable. A handshake (out_valid & out_ready) returns the FSM to IDLE.
- Fill bits:
  - SLL and SRL fill with 0.
  - SRA fills with in_data[WIDTH-1], captured at accept.
  - ROTR fills with the bits shifted out of the LSB end.
- in_valid and in_data are ignored outside IDLE, with no buffering.
- Reset values: state IDLE, in_ready 1, out_valid 0, out_data 0, out_lost 0, remaining 0.
- Reset mid-operation aborts the operation immediately. No result is produced, and the first post-reset handshake is processed normally.

## Timing
- Let N = ceil(in_shamt/STEP).
- out_valid rises 1+N rising edges after the accept edge; shamt=0 gives 1 edge.
- Back-to-back operations cost one IDLE cycle between the DONE handshake and the next accept.
- The outputs are registered. in_ready is decoded from state only, with no combinational path from out_ready or in_valid.
- out_data stays stable for the whole of DONE regardless of out_ready.

## Configuration
- SHIFT_ROTATE_EN defined: mode 11 performs rotate right, and out_lost is 0 for rotate operations.
- SHIFT_ROTATE_EN undefined: the rotate path is not built, and mode 11 executes as SLL, including out_lost.

## Structure
- Package shift_pkg holds:
  - the mode typedef (SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROTR);
  - the FSM state typedef (ST_IDLE, ST_SHIFT, ST_DONE).
- Sub-module shift_step is the combinational one-step shifter. It takes data, amount k (0..STEP), mode and fill, and returns the shifted data plus an any-bit-lost flag.
- shift_unit holds the FSM, the registers and the handshakes.

## Test plan
All cases use WIDTH=32, STEP=4 unless noted.
- SLL: in_data 0x0000_0001, shamt 2 → out_data 0x0000_0004, out_lost 0, out_valid 2 edges after accept.
- SRA: in_data 0x8000_0000, shamt 31 → out_data 0xFFFF_FFFF, out_lost 0, N=8, out_valid 9 edges after accept.
- SLL loss: in_data 0xC000_0000, shamt 1 → out_data 0x8000_0000, out_lost 1. SRL 0x0000_0003 by 1 → 0x0000_0001, out_lost 1.
- Backpressure: out_ready held 0 for 5 cycles in DONE → out_valid and out_data stable and in_ready 0 throughout. An in_valid pulse during that time is ignored; accept resumes 1 cycle after the out handshake.
- Reset mid-SHIFT: Reset asserted at SHIFT cycle 3 of a shamt=20 SRL → out_valid 0, in_ready 1, out_data 0 immediately. Then SRL 0xF000_0000 by 4 → 0x0F00_0000.
- Mode 11, shamt 0 → zero-amount case: out_data 0x0000_00F1 after 1 edge.
- Mode 11 with SHIFT_ROTATE_EN: 0x0000_00F1 by 4 → 0x1000_000F, out_lost 0.
- Mode 11 without SHIFT_ROTATE_EN: same input → 0x0000_0F10, out_lost 0.
